// File: rtl/sha1_pkg.sv
// Shared constants and FSM state type for the SHA-1 message padder.
package sha1_pkg;

    localparam int unsigned N          = 32;
    localparam int unsigned BLOCK_W    = 512;
    localparam int unsigned WORDS      = 16;
    localparam logic [31:0] PAD_WORD   = 32'h8000_0000;
    localparam logic [3:0]  LEN_HI_IDX = 4'd14;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        LEN,
        OUT
    } state_t;

endpackage

// File: rtl/sha1_pad_word.sv
// Formats the final message word: keeps the valid MSB-first bytes, appends 0x80,
// and flags a full word whose 0x80 marker must go into the following word.
module sha1_pad_word
    import sha1_pkg::*;
(
    input  logic [31:0] in_data,
    input  logic [2:0]  in_nbytes,
    output logic [31:0] word,
    output logic [2:0]  nbytes,
    output logic        pad_pending
);

    always_comb begin
        word        = PAD_WORD;
        nbytes      = in_nbytes;
        pad_pending = 1'b0;
        case (in_nbytes)
            3'd0: word = PAD_WORD;
            3'd1: word = {in_data[31:24], 8'h80, 16'h0000};
            3'd2: word = {in_data[31:16], 8'h80, 8'h00};
            3'd3: word = {in_data[31:8], 8'h80};
            default: begin
                // Counts above 4 saturate to a full word.
                word        = in_data;
                nbytes      = 3'd4;
                pad_pending = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs 32-bit big-endian words into 512-bit blocks and
// appends the 0x80 marker, zero fill and 64-bit bit-length.
module sha1_padder #(
    parameter int N     = 32,
    parameter int LEN_W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    input  logic           in_last,
    input  logic [2:0]     in_nbytes,
    output logic           blk_valid,
    input  logic           blk_ready,
    output logic [511:0]   blk_data,
    output logic           blk_last
);
    import sha1_pkg::*;

    state_t                   state;
    state_t                   ret_state;
    logic [0:WORDS-1][31:0]   blk_buf;
    logic [3:0]               ptr;
    logic [LEN_W-1:0]         bitlen;
    logic                     pad_pending;
    logic                     final_q;

    logic [31:0]              fmt_word;
    logic [2:0]               fmt_nbytes;
    logic                     fmt_pad;
    logic [63:0]              len_field;

    sha1_pad_word u_pad_word (
        .in_data     (in_data),
        .in_nbytes   (in_nbytes),
        .word        (fmt_word),
        .nbytes      (fmt_nbytes),
        .pad_pending (fmt_pad)
    );

    assign in_ready  = (state == FILL);
    assign len_field = 64'(bitlen);
    // Word 0 is the most significant slice, matching the schedule's W0 ordering.
    assign blk_data  = blk_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            ret_state   <= FILL;
            blk_buf     <= '0;
            ptr         <= '0;
            bitlen      <= '0;
            pad_pending <= 1'b0;
            final_q     <= 1'b0;
            blk_valid   <= 1'b0;
            blk_last    <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        ptr <= ptr + 4'd1;
                        if (!in_last) begin
                            blk_buf[ptr] <= in_data;
                            bitlen       <= bitlen + LEN_W'(32);
                            if (ptr == 4'd15) begin
                                state     <= OUT;
                                ret_state <= FILL;
                                blk_valid <= 1'b1;
                            end
                        end else begin
                            blk_buf[ptr] <= fmt_word;
                            pad_pending  <= fmt_pad;
                            bitlen       <= bitlen + LEN_W'({fmt_nbytes, 3'b000});
                            if (ptr == 4'd15) begin
                                state     <= OUT;
                                ret_state <= PAD;
                                blk_valid <= 1'b1;
                            end else begin
                                state <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    // Words 14/15 are reserved for the length once the marker is placed.
                    if (!pad_pending && ptr == LEN_HI_IDX) begin
                        state <= LEN;
                    end else begin
                        blk_buf[ptr] <= pad_pending ? PAD_WORD : '0;
                        pad_pending  <= 1'b0;
                        ptr          <= ptr + 4'd1;
                        if (ptr == 4'd15) begin
                            state     <= OUT;
                            ret_state <= PAD;
                            blk_valid <= 1'b1;
                        end
                    end
                end
                LEN: begin
                    blk_buf[LEN_HI_IDX]        <= len_field[63:32];
                    blk_buf[LEN_HI_IDX + 4'd1] <= len_field[31:0];
                    final_q                    <= 1'b1;
                    blk_valid                  <= 1'b1;
                    blk_last                   <= 1'b1;
                    state                      <= OUT;
                end
                OUT: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_last  <= 1'b0;
                        ptr       <= '0;
                        if (final_q) begin
                            final_q <= 1'b0;
                            bitlen  <= '0;
                            state   <= FILL;
                        end else begin
                            state <= ret_state;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
